// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
// The package holds the FSM state, the read-owner encoding and the read-latency range check.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Wide enough to hold RD_LAT_MAX.
  localparam int CNT_W      = 3;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Fair arbiter sharing one single-port memory between instruction fetch and load/store.
// It allows one read in flight and returns data to the owner after a fixed read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("mem_port_arbiter: RD_LATENCY must lie in 1..4");
  end

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_ls_q, last_ls_d;

  logic rvalid_cycle;
  logic eligible;
  logic win_if;
  logic win_ls;
  logic store_gnt;
  logic rd_gnt;

  // Grants are gated by rst_n so that every output is 0 while reset is held.
  always_comb begin
    rvalid_cycle = (state_q == ST_RD_WAIT) && (cnt_q == CNT_W'(1));
    eligible     = rst_n && ((state_q == ST_IDLE) || rvalid_cycle);
    win_ls       = eligible && ls_req && (!if_req || !last_ls_q);
    win_if       = eligible && if_req && !win_ls;
    store_gnt    = win_ls && ls_we;
    rd_gnt       = win_if || (win_ls && !ls_we);
  end

  always_comb begin
    if_gnt    = win_if;
    ls_gnt    = win_ls;
    if_rvalid = rvalid_cycle && (owner_q == OWN_IF);
    ls_rvalid = rvalid_cycle && (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    mem_re    = rd_gnt;
    mem_we    = store_gnt ? ls_wmask : '0;
    mem_wdata = store_gnt ? ls_wdata : '0;
    busy      = (state_q == ST_RD_WAIT);
    if (win_if) begin
      mem_addr = if_addr;
    end else if (win_ls) begin
      mem_addr = ls_addr;
    end else begin
      mem_addr = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_ls_d = last_ls_q;
    if (win_if || win_ls) begin
      last_ls_d = win_ls;
    end
    // A read granted in the rvalid cycle takes over the wait state directly.
    if (rd_gnt) begin
      state_d = ST_RD_WAIT;
      owner_d = win_if ? OWN_IF : OWN_LS;
      cnt_d   = CNT_W'(RD_LATENCY);
    end else if (state_q == ST_RD_WAIT) begin
      if (rvalid_cycle) begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      last_ls_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_ls_q <= last_ls_d;
    end
  end

endmodule
